// File: rtl/music_pkg.sv
// Shared audio-path types and helpers: sample width, echo FSM states and a
// saturating adder used by the echo mixer.
package music_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {IDLE, READ, MIX, OUT} echo_state_t;

  // Two's-complement add clamped to the representable SAMPLE_W range.
  function automatic logic signed [SAMPLE_W-1:0] sat_add(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b
  );
    logic signed [SAMPLE_W:0] s;
    s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (s[SAMPLE_W] != s[SAMPLE_W-1])
      return s[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    return s[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/echo_unit_ram.sv
// Single-port synchronous RAM for the echo delay line; read-before-write so a
// write cycle still returns the old word.
module echo_ram #(
  parameter int DELAY_LOG2 = 10,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DELAY_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DELAY_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_unit.sv
// Feedback echo stage: mixes each input sample with an attenuated copy of the
// output 2^DELAY_LOG2 samples earlier. ECHO_SAT_EN selects saturating mix.
module echo_unit
  import music_pkg::*;
#(
  parameter int DELAY_LOG2 = 10,
  parameter int WIDTH      = SAMPLE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play_enable,
  input  logic                    toggle_echo,
  input  logic [1:0]              decay_pow,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_in_ready,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    echo_sample_ready,
  output logic                    primed
);

  echo_state_t             state_q, state_d;
  logic [DELAY_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic signed [WIDTH-1:0] in_q, in_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic                    primed_q, primed_d;

  logic                    ram_we;
  logic [WIDTH-1:0]        ram_rdata;
  logic signed [WIDTH-1:0] delayed, echo, sum, mix;
  logic [2:0]              shamt;

  echo_ram #(.DELAY_LOG2(DELAY_LOG2), .WIDTH(WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (wr_ptr_q),
    .wdata (mix),
    .rdata (ram_rdata)
  );

  // Unwritten RAM words are garbage until the pointer has wrapped once.
  always_comb begin
    delayed = primed_q ? $signed(ram_rdata) : '0;
    shamt   = {1'b0, decay_pow} + 3'd1;
    echo    = delayed >>> shamt;
`ifdef ECHO_SAT_EN
    sum     = sat_add(in_q, echo);
`else
    sum     = in_q + echo;
`endif
    mix     = toggle_echo ? sum : in_q;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    in_d     = in_q;
    out_d    = out_q;
    primed_d = primed_q;
    ram_we   = 1'b0;
    case (state_q)
      IDLE: if (sample_in_ready && play_enable) begin
        in_d    = sample_in;
        state_d = READ;
      end
      READ: state_d = MIX;
      MIX: begin
        ram_we  = 1'b1;
        out_d   = mix;
        state_d = OUT;
      end
      OUT: begin
        wr_ptr_d = wr_ptr_q + {{(DELAY_LOG2-1){1'b0}}, 1'b1};
        if (&wr_ptr_q) primed_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      in_q     <= '0;
      out_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      in_q     <= in_d;
      out_q    <= out_d;
      primed_q <= primed_d;
    end
  end

  assign sample_out        = out_q;
  assign echo_sample_ready = (state_q == OUT);
  assign primed            = primed_q;

endmodule

// File: tb/tb_echo_unit.sv
// Directed bench for echo_unit with an 8-deep delay line; expected values are
// hand-computed from the slot contents written by earlier samples.
module tb_echo_unit;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               play_enable = 1'b1;
  logic               toggle_echo = 1'b1;
  logic [1:0]         decay_pow = 2'd0;
  logic signed [15:0] sample_in = '0;
  logic               sample_in_ready = 1'b0;
  logic signed [15:0] sample_out;
  logic               echo_sample_ready;
  logic               primed;

  int n_cmp = 0;
  int n_bad = 0;

  echo_unit #(.DELAY_LOG2(3), .WIDTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .play_enable       (play_enable),
    .toggle_echo       (toggle_echo),
    .decay_pow         (decay_pow),
    .sample_in         (sample_in),
    .sample_in_ready   (sample_in_ready),
    .sample_out        (sample_out),
    .echo_sample_ready (echo_sample_ready),
    .primed            (primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One strobe; wait (bounded) for the output strobe and confirm it is one cycle.
  task automatic send(input int s, output int got, output int lat);
    @(posedge clk); #1;
    sample_in = 16'(s);
    sample_in_ready = 1'b1;
    @(posedge clk); #1;
    sample_in_ready = 1'b0;
    lat = 0;
    got = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (echo_sample_ready) begin
        lat = k + 1;
        got = sample_out;
        break;
      end
    end
    if (lat == 0) chk("timeout", 0, 1);
    else begin
      @(posedge clk); #1;
      chk("oneshot", echo_sample_ready, 0);
    end
  endtask

  task automatic sendc(input string tag, input int s, input int exp);
    int got, lat;
    send(s, got, lat);
    chk(tag, got, exp);
  endtask

  task automatic run(input int s);
    int got, lat;
    send(s, got, lat);
  endtask

  initial begin
    int got, lat, cnt;
    #12;
    chk("rst_out", sample_out, 0);
    chk("rst_rdy", echo_sample_ready, 0);
    chk("rst_primed", primed, 0);
    @(negedge clk);
    reset = 1'b1;

    // Samples 1..8 fill slots 0..7; echo is masked until the first wrap.
    send(1000, got, lat);
    chk("lat", lat, 3);
    chk("first", got, 1000);
    for (int i = 0; i < 6; i++) run(0);
    chk("primed_pre", primed, 0);
    run(0);
    chk("primed_post", primed, 1);
    sendc("echo9", 0, 500);
    for (int i = 0; i < 7; i++) run(0);
    sendc("echo17", 0, 250);

    // Bypass-fill every slot with full scale, then overflow the mix.
    toggle_echo = 1'b0;
    sendc("bypass_fill", 32767, 32767);
    for (int i = 0; i < 7; i++) run(32767);
    toggle_echo = 1'b1;
`ifdef ECHO_SAT_EN
    sendc("sat", 30000, 32767);
`else
    sendc("wrap", 30000, -19153);
`endif

    // Bypass writes the raw input into slot 2.
    toggle_echo = 1'b0;
    sendc("bypass", -1234, -1234);
    toggle_echo = 1'b1;
    decay_pow = 2'd1;
    sendc("decay1", 0, 8191);
    decay_pow = 2'd0;
    sendc("mix_s4", 10, 16393);
    for (int i = 0; i < 4; i++) run(0);
`ifdef ECHO_SAT_EN
    sendc("echo_sat", 0, 16383);
`else
    sendc("echo_wrap", 0, -9577);
`endif
    sendc("reenable", 0, -617);

    // Second strobe while busy must be dropped.
    @(posedge clk); #1;
    sample_in = 16'sd100; sample_in_ready = 1'b1;
    @(posedge clk); #1;
    sample_in = 16'sd200;
    @(posedge clk); #1;
    sample_in_ready = 1'b0;
    cnt = 0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (echo_sample_ready) begin cnt++; got = sample_out; end
    end
    chk("busy_cnt", cnt, 1);
    chk("busy_val", got, 4195);

    // play_enable low: strobe ignored, pointer holds (slot 4 is next).
    play_enable = 1'b0;
    @(posedge clk); #1;
    sample_in = 16'sd321; sample_in_ready = 1'b1;
    @(posedge clk); #1;
    sample_in_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (echo_sample_ready) cnt++;
    end
    chk("pe_cnt", cnt, 0);
    chk("pe_hold", sample_out, 4195);
    play_enable = 1'b1;
    sendc("pe_ptr", 0, 8196);

    // Async reset landing in MIX.
    @(posedge clk); #1;
    sample_in = 16'sd555; sample_in_ready = 1'b1;
    @(posedge clk); #1;
    sample_in_ready = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("arst_out", sample_out, 0);
    chk("arst_rdy", echo_sample_ready, 0);
    chk("arst_primed", primed, 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (echo_sample_ready) cnt++;
    end
    chk("arst_nostrobe", cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    sendc("post_rst", 700, 700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/echo_unit.md
Name: echo_unit

Overview:
- Audio effect stage directly downstream of the dynamics block.
- Consumes each enveloped 16-bit signed sample when `dynamic_sample_ready` pulses, and mixes it with an attenuated copy of the output from 2^DELAY_LOG2 samples earlier (feedback echo).
- Emits the result with a one-cycle valid strobe towards the codec interface.
- The delay line is a circular buffer in a single-port synchronous RAM.

Parameters:
- DELAY_LOG2, 10: log2 of the echo delay in samples; buffer depth is 2^DELAY_LOG2.
- WIDTH, 16: sample width, two's complement.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_enable  in  1  processing enabled; when low, input strobes are ignored
- toggle_echo  in  1  1 = echo mixed in; 0 = bypass (same latency)
- decay_pow  in  2  echo attenuation: delayed term is arithmetically shifted right by decay_pow+1
- sample_in  in  WIDTH  sample from dynamics (dynamics_sample_out)
- sample_in_ready  in  1  one-cycle strobe, sample_in valid (dynamic_sample_ready)
- sample_out  out  WIDTH  echoed sample, registered
- echo_sample_ready  out  1  one-cycle strobe, sample_out updated
- primed  out  1  buffer has wrapped at least once

Behaviour:
- Reset (reset low, async):
  - sample_out=0, echo_sample_ready=0, primed=0.
  - wr_ptr=0, FSM=IDLE, captured sample register=0.
  - RAM contents are not cleared; primed masks them.
- FSM states IDLE, READ, MIX, OUT:
  - IDLE: on sample_in_ready && play_enable, capture sample_in, present wr_ptr to RAM read port, go to READ.
  - READ: RAM read data is valid next cycle; go to MIX.
  - MIX: compute the mixed value (below), write it to RAM[wr_ptr], register it into sample_out, go to OUT.
  - OUT: echo_sample_ready=1 for exactly this cycle; increment wr_ptr; go to IDLE.
- Mixed value:
  - delayed = primed ? RAM[wr_ptr] : 0.
  - echo = delayed >>> (decay_pow+1).
  - sum = sign-extend(in) + sign-extend(echo), WIDTH+1 bits.
  - Result is saturated to [-32768, 32767].
  - When toggle_echo=0: result = captured input, and that input is written to RAM (the delay line stays coherent for re-enable).
- Latency: strobe in cycle N → echo_sample_ready high in cycle N+3, sample_out valid from N+3 and held until the next update.
- Wrap: wr_ptr is DELAY_LOG2 bits and wraps from 2^DELAY_LOG2-1 to 0. primed sets on the first wrap and stays set until reset.
- Busy handling: sample_in_ready while not in IDLE is dropped (no queueing). Upstream spacing is ≥4 cycles by construction; the bench checks that drops occur only when spacing is violated.
- play_enable:
  - Low in IDLE: strobes are ignored; sample_out holds; wr_ptr and primed hold.
  - Falling mid-operation: the current sample completes normally.
- decay_pow and toggle_echo are sampled in MIX; changes take effect on the next sample.
- Reset asserted mid-operation: immediate return to the reset state. No echo_sample_ready is emitted for the in-flight sample.
- Simultaneous sample_in_ready and OUT: the strobe is dropped, since the FSM is not in IDLE.

Optional Feature:
- Macro ECHO_SAT_EN.
- Defined: the sum is saturated as described.
- Undefined: the sum is truncated to WIDTH bits (wrap-around). Saves logic; the bench expects wrapped values.

Decomposition:
- Shared package music_pkg holds:
  - SAMPLE_W=16 constant.
  - echo_state_t enum {IDLE, READ, MIX, OUT}.
  - Function sat_add(a,b) returning a saturated WIDTH-bit sum.
- Natural sub-module: echo_ram, a single-port synchronous-read RAM.
  - Ports: clk, we, addr[DELAY_LOG2], wdata[WIDTH], rdata[WIDTH].
  - Behaviour: read-before-write, inferable as block RAM.

Test Plan:
- Reset/latency: release reset, toggle_echo=1, strobe sample_in=1000 → echo_sample_ready exactly 3 cycles later, sample_out=1000 (primed=0, so echo is 0).
- Echo after wrap: DELAY_LOG2=3, decay_pow=0, feed 1000 then seven 0s → primed rises after the 8th sample; 9th input 0 gives sample_out=500, 17th gives 250.
- Saturation: primed buffer holding 32767, decay_pow=0, input 30000 → sample_out=32767. With ECHO_SAT_EN undefined → 46383 wraps to -19153.
- Bypass: toggle_echo=0, primed buffer non-zero, input -1234 → sample_out=-1234. After re-enable, the sample 2^DELAY_LOG2 later sees -617 as the echo contribution (decay_pow=0).
- Busy/play_enable: second strobe 1 cycle after the first → exactly one echo_sample_ready. play_enable=0 strobe → no output, wr_ptr unchanged.
- Async reset mid-MIX: assert reset low between clock edges → outputs 0 immediately, no strobe. After release, the next sample is processed with primed=0.
